// File: rtl/ram_model_pkg.sv
// rtl/ram_model_pkg.sv - shared types and helpers for the burst latency RAM model
package ram_model_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_READ,
        ST_WRITE
    } ram_state_e;

    // Power-up content: every byte of word i holds i[7:0].
    function automatic logic [7:0] init_byte(input logic [31:0] word);
        return word[7:0];
    endfunction

    // Burst lengths that are not a power of two within 1..max_burst collapse to a single beat.
    function automatic int legal_burst(input int len, input int max_burst);
        if (len >= 1 && len <= max_burst && (len & (len - 1)) == 0) begin
            return len;
        end
        return 1;
    endfunction

endpackage

// File: rtl/burst_addr_gen.sv
// rtl/burst_addr_gen.sv - wrapped beat address for critical-word-first bursts
module burst_addr_gen #(
    parameter int WW  = 14,
    parameter int BLW = 3
) (
    input  logic [WW-1:0]  start,
    input  logic [BLW-1:0] beats,
    input  logic [BLW-1:0] index,
    output logic [WW-1:0]  addr
);

    logic [WW-1:0] mask;

    // Low log2(beats) bits advance modulo beats; upper bits stay at the start line.
    assign mask = WW'(beats) - WW'(1);
    assign addr = (start & ~mask) | ((start + WW'(index)) & mask);

endmodule

// File: rtl/burst_latency_ram.sv
// rtl/burst_latency_ram.sv - behavioural external RAM with latency, wrapping bursts and byte enables
module burst_latency_ram
    import ram_model_pkg::*;
#(
    parameter int ADDRESS_WIDTH = 16,
    parameter int DATA_WIDTH    = 32,
    parameter int LATENCY       = 1,
    parameter int MAX_BURST     = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         ram_rd,
    input  logic                         ram_wr,
    input  logic [ADDRESS_WIDTH-1:0]     ram_address,
    input  logic [$clog2(MAX_BURST):0]   ram_burst_len,
    input  logic [DATA_WIDTH/8-1:0]      ram_byte_enable,
    input  logic [DATA_WIDTH-1:0]        ram_data_wr,
    output logic                         ram_ready,
    output logic                         ram_wr_accept,
    output logic [DATA_WIDTH-1:0]        ram_data_rd,
    output logic                         ram_data_valid
);

    localparam int BYTES = DATA_WIDTH / 8;
    localparam int BW    = $clog2(BYTES);
    localparam int WW    = ADDRESS_WIDTH - BW;
    localparam int WORDS = 2 ** WW;
    localparam int BLW   = $clog2(MAX_BURST) + 1;
    localparam int WAITW = (LATENCY > 2) ? $clog2(LATENCY - 1) : 1;

    ram_state_e state, state_next;

    logic [WW-1:0]  start_q, start_cur, req_start, beat_addr;
    logic [BLW-1:0] beats_q, beats_cur, req_beats;
    logic [BLW-1:0] idx_q, idx_cur, idx_next;
    logic [WAITW-1:0] wait_q, wait_next;
    logic wr_q, wr_cur;
    logic accept, beat_go;
    logic [DATA_WIDTH-1:0] data_rd_q;
    logic data_valid_q;
    logic unused_low_addr;

    // Storage holds each word XOR its init pattern, so an all-zero power-up array reads back
    // as the init pattern and reset never touches memory contents.
    logic [DATA_WIDTH-1:0] delta [WORDS];

    function automatic logic [DATA_WIDTH-1:0] pattern_word(input logic [WW-1:0] w);
        return {BYTES{init_byte(32'(w))}};
    endfunction

    assign unused_low_addr = ^ram_address[BW-1:0];
    assign req_start = ram_address[ADDRESS_WIDTH-1:BW];
    assign req_beats = BLW'(legal_burst(int'(ram_burst_len), MAX_BURST));
    assign accept    = (state == ST_IDLE) && (ram_rd || ram_wr);

    // In IDLE the beat context comes straight from the request; afterwards from the latched copy.
    always_comb begin
        start_cur = start_q;
        beats_cur = beats_q;
        wr_cur    = wr_q;
        idx_cur   = idx_q;
        if (state == ST_IDLE) begin
            start_cur = req_start;
            beats_cur = req_beats;
            wr_cur    = !ram_rd;
            idx_cur   = '0;
        end
    end

    burst_addr_gen #(
        .WW  (WW),
        .BLW (BLW)
    ) u_addr_gen (
        .start (start_cur),
        .beats (beats_cur),
        .index (idx_cur),
        .addr  (beat_addr)
    );

    // Next-state logic; beat_go marks the cycle whose closing edge performs a beat.
    always_comb begin
        state_next = state;
        idx_next   = idx_q;
        wait_next  = wait_q;
        beat_go    = 1'b0;
        case (state)
            ST_IDLE: begin
                if (accept) begin
                    idx_next  = '0;
                    wait_next = '0;
                    if (LATENCY == 1) begin
                        beat_go    = 1'b1;
                        idx_next   = BLW'(1);
                        state_next = wr_cur ? ST_WRITE : ST_READ;
                    end else begin
                        state_next = ST_WAIT;
                    end
                end
            end
            ST_WAIT: begin
                if (wait_q == WAITW'(LATENCY - 2)) begin
                    beat_go    = 1'b1;
                    idx_next   = BLW'(1);
                    state_next = wr_q ? ST_WRITE : ST_READ;
                end else begin
                    wait_next = wait_q + WAITW'(1);
                end
            end
            ST_READ, ST_WRITE: begin
                if (idx_q < beats_q) begin
                    beat_go  = 1'b1;
                    idx_next = idx_q + BLW'(1);
                end else begin
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // State, latched request and registered read outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= ST_IDLE;
            idx_q        <= '0;
            wait_q       <= '0;
            start_q      <= '0;
            beats_q      <= '0;
            wr_q         <= 1'b0;
            data_rd_q    <= '0;
            data_valid_q <= 1'b0;
        end else begin
            state  <= state_next;
            idx_q  <= idx_next;
            wait_q <= wait_next;
            if (accept) begin
                start_q <= start_cur;
                beats_q <= beats_cur;
                wr_q    <= wr_cur;
            end
            data_valid_q <= beat_go && (!wr_cur || idx_next == beats_cur);
            if (beat_go && !wr_cur) begin
                data_rd_q <= delta[beat_addr] ^ pattern_word(beat_addr);
            end
        end
    end

    // Byte-enabled write of the current beat; reset blocks the write but keeps stored data.
    always_ff @(posedge clk or posedge rst) begin
        if (!rst && beat_go && wr_cur) begin
            for (int b = 0; b < BYTES; b++) begin
                if (ram_byte_enable[b]) begin
                    delta[beat_addr][b*8 +: 8] <= ram_data_wr[b*8 +: 8] ^ init_byte(32'(beat_addr));
                end
            end
        end
    end

    assign ram_ready      = (state == ST_IDLE);
    assign ram_wr_accept  = beat_go && wr_cur;
    assign ram_data_rd    = data_rd_q;
    assign ram_data_valid = data_valid_q;

endmodule

// File: tb/tb_burst_latency_ram.sv
// tb/tb_burst_latency_ram.sv - directed self-checking bench for burst_latency_ram at latencies 1..3
module tb_burst_latency_ram;

    logic clk = 1'b0;
    logic rst;

    logic        rd     [3];
    logic        wr     [3];
    logic [15:0] addr   [3];
    logic [2:0]  blen   [3];
    logic [3:0]  be     [3];
    logic [31:0] wdata  [3];
    logic        ready  [3];
    logic        wacc   [3];
    logic [31:0] rdata  [3];
    logic        valid  [3];

    int vectors = 0;
    int errs    = 0;

    logic [31:0] exp_l3 [4];
    logic [31:0] exp_l2 [4];

    always #5 clk = ~clk;

    // Instance g runs with LATENCY = g+1.
    for (genvar g = 0; g < 3; g++) begin : g_dut
        burst_latency_ram #(
            .ADDRESS_WIDTH (16),
            .DATA_WIDTH    (32),
            .LATENCY       (g + 1),
            .MAX_BURST     (4)
        ) dut (
            .clk             (clk),
            .rst             (rst),
            .ram_rd          (rd[g]),
            .ram_wr          (wr[g]),
            .ram_address     (addr[g]),
            .ram_burst_len   (blen[g]),
            .ram_byte_enable (be[g]),
            .ram_data_wr     (wdata[g]),
            .ram_ready       (ready[g]),
            .ram_wr_accept   (wacc[g]),
            .ram_data_rd     (rdata[g]),
            .ram_data_valid  (valid[g])
        );
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chkb(input string tag, input logic obs, input logic exp);
        vectors++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    initial begin
        exp_l3[0] = 32'h0A0A0A0A; exp_l3[1] = 32'h0B0B0B0B;
        exp_l3[2] = 32'h08080808; exp_l3[3] = 32'h09090909;
        exp_l2[0] = 32'hA0000000; exp_l2[1] = 32'hA0000001;
        exp_l2[2] = 32'h42424242; exp_l2[3] = 32'h43434343;

        for (int g = 0; g < 3; g++) begin
            rd[g] = 1'b0; wr[g] = 1'b0; addr[g] = '0; blen[g] = 3'd1;
            be[g] = '0; wdata[g] = '0;
        end
        rst = 1'b1;
        repeat (2) tick();
        for (int g = 0; g < 3; g++) begin
            chkb("reset_ready", ready[g], 1'b1);
            chkb("reset_valid", valid[g], 1'b0);
            chkb("reset_wr_accept", wacc[g], 1'b0);
            chk("reset_data_rd", rdata[g], 32'h0);
        end
        rst = 1'b0;
        tick();

        // LATENCY=1 single read at 0x0020
        rd[0] = 1'b1; addr[0] = 16'h0020; blen[0] = 3'd1;
        #1 chkb("l1_rd_ready_c", ready[0], 1'b1);
        tick();
        rd[0] = 1'b0;
        chkb("l1_rd_valid", valid[0], 1'b1);
        chk("l1_rd_data", rdata[0], 32'h08080808);
        chkb("l1_rd_ready_busy", ready[0], 1'b0);
        tick();
        chkb("l1_rd_valid_end", valid[0], 1'b0);
        chkb("l1_rd_ready_back", ready[0], 1'b1);

        // LATENCY=3 wrapping read of 4 beats at 0x0028
        rd[2] = 1'b1; addr[2] = 16'h0028; blen[2] = 3'd4;
        tick();
        rd[2] = 1'b0;
        for (int k = 1; k <= 6; k++) begin
            chkb("l3_ready_low", ready[2], 1'b0);
            chkb("l3_valid", valid[2], k >= 3);
            if (k >= 3) chk("l3_beat", rdata[2], exp_l3[k-3]);
            tick();
        end
        chkb("l3_ready_back", ready[2], 1'b1);
        chkb("l3_valid_end", valid[2], 1'b0);

        // Single-beat write with one byte enabled at 0xD030
        wr[0] = 1'b1; addr[0] = 16'hD030; blen[0] = 3'd1; be[0] = 4'b0001; wdata[0] = 32'h12345678;
        #1 chkb("wr_accept_c", wacc[0], 1'b1);
        tick();
        wr[0] = 1'b0;
        chkb("wr_done_pulse", valid[0], 1'b1);
        chk("wr_done_data_held", rdata[0], 32'h08080808);
        chkb("wr_done_ready", ready[0], 1'b0);
        chkb("wr_done_no_accept", wacc[0], 1'b0);
        tick();
        chkb("wr_ready_back", ready[0], 1'b1);
        rd[0] = 1'b1; addr[0] = 16'hD030;
        tick();
        rd[0] = 1'b0;
        chk("wr_readback", rdata[0], 32'h0C0C0C78);
        tick();

        // Read and write together: read wins, write dropped
        rd[0] = 1'b1; wr[0] = 1'b1; addr[0] = 16'h0040; be[0] = 4'hF; wdata[0] = 32'hDEADBEEF;
        #1 chkb("both_no_accept_c", wacc[0], 1'b0);
        tick();
        rd[0] = 1'b0; wr[0] = 1'b0;
        chkb("both_valid", valid[0], 1'b1);
        chk("both_data", rdata[0], 32'h10101010);
        chkb("both_no_accept_c1", wacc[0], 1'b0);
        tick();
        rd[0] = 1'b1;
        tick();
        rd[0] = 1'b0;
        chk("both_mem_unchanged", rdata[0], 32'h10101010);
        tick();

        // Illegal burst length 3 collapses to one beat
        rd[0] = 1'b1; addr[0] = 16'h0004; blen[0] = 3'd3;
        tick();
        rd[0] = 1'b0;
        chkb("len3_valid", valid[0], 1'b1);
        chk("len3_data", rdata[0], 32'h01010101);
        tick();
        chkb("len3_single_beat", valid[0], 1'b0);
        chkb("len3_ready_back", ready[0], 1'b1);

        // LATENCY=2 burst write interrupted by reset after beat 1
        wr[1] = 1'b1; addr[1] = 16'h0100; blen[1] = 3'd4; be[1] = 4'hF; wdata[1] = 32'hA0000000;
        #1 chkb("l2_wr_no_accept_c", wacc[1], 1'b0);
        chkb("l2_wr_ready_c", ready[1], 1'b1);
        tick();
        wr[1] = 1'b0;
        #1 chkb("l2_wr_beat0", wacc[1], 1'b1);
        chkb("l2_wr_busy", ready[1], 1'b0);
        tick();
        wdata[1] = 32'hA0000001;
        #1 chkb("l2_wr_beat1", wacc[1], 1'b1);
        tick();
        rst = 1'b1;
        #1 chkb("rst_mid_ready", ready[1], 1'b1);
        chkb("rst_mid_valid", valid[1], 1'b0);
        chkb("rst_mid_wr_accept", wacc[1], 1'b0);
        chk("rst_mid_data_rd", rdata[1], 32'h0);
        tick();
        rst = 1'b0;
        rd[1] = 1'b1; addr[1] = 16'h0100; blen[1] = 3'd4;
        #1 chkb("post_rst_ready", ready[1], 1'b1);
        tick();
        rd[1] = 1'b0;
        chkb("post_rst_accepted", ready[1], 1'b0);
        chkb("post_rst_wait_valid", valid[1], 1'b0);
        tick();
        for (int k = 0; k < 4; k++) begin
            chkb("post_rst_valid", valid[1], 1'b1);
            chk("post_rst_beat", rdata[1], exp_l2[k]);
            tick();
        end
        chkb("post_rst_valid_end", valid[1], 1'b0);
        chkb("post_rst_ready_back", ready[1], 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end

endmodule

// File: doc/burst_latency_ram.md
# burst_latency_ram

Parametrised behavioural external-RAM model that supersedes the single-beat simulated RAM used by the cache benches. Adds configurable access latency, power-of-two wrapping bursts (critical-word-first line fills), per-byte write enables and a ready handshake. It sits on the cache's RAM-side port in all cache testbenches. With LATENCY=1 and burst length 1, it is cycle-compatible with the single-beat model.

## Interface
- ADDRESS_WIDTH, 16, byte-address width.
- DATA_WIDTH, 32, beat width; a multiple of 8.
- LATENCY, 1, cycles from the request cycle to the first read beat; ≥1.
- MAX_BURST, 4, maximum beats per burst; a power of two.
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-high.
- ram_rd  in  1  read request.
- ram_wr  in  1  write request.
- ram_address  in  ADDRESS_WIDTH  byte address; low $clog2(DATA_WIDTH/8) bits are ignored.
- ram_burst_len  in  $clog2(MAX_BURST)+1  beat count.
- ram_byte_enable  in  DATA_WIDTH/8  per-byte write enable; sampled on every write beat.
- ram_data_wr  in  DATA_WIDTH  write beat data.
- ram_ready  out  1  request accepted this cycle if asserted.
- ram_wr_accept  out  1  current write beat is consumed at this edge.
- ram_data_rd  out  DATA_WIDTH  read beat data, registered.
- ram_data_valid  out  1  read beat valid, or single-cycle write-done pulse.

## Operation
- Storage is 2**(ADDRESS_WIDTH-$clog2(DATA_WIDTH/8)) words.
- Init pattern: every byte of word i equals i[7:0]. It is applied at time 0 only and is not reapplied on rst.
- States: IDLE, WAIT, READ, WRITE.
- ram_ready = (state==IDLE).
- A request is accepted when ram_ready && (ram_rd || ram_wr).
  - If both are high, the read wins and the write is dropped.
  - On acceptance, latch the word address, op and beats.
- Beats: ram_burst_len must be a power of two in 1..MAX_BURST. Any other value, including 0, is treated as 1.
- Wrap: beat k addresses the word whose low log2(beats) bits are (start+k) mod beats; the upper bits stay fixed. The address space also wraps modulo its size.
- IDLE -> WAIT on acceptance when LATENCY>1. The wait counter counts LATENCY-1 cycles in WAIT, then moves to READ or WRITE.
- IDLE -> READ or WRITE directly when LATENCY==1. For a write, beat 0 is consumed in the request cycle itself.
- READ: one beat per cycle. ram_data_valid=1 and ram_data_rd = mem[beat addr]. Returns to IDLE after the last beat.
- WRITE: ram_wr_accept=1 each beat. At the edge, bytes with ram_byte_enable set are updated. After the last beat, ram_data_valid pulses for one cycle with ram_data_rd unchanged, and the FSM returns to IDLE.
- Reads ignore ram_byte_enable.
- Requests are ignored while ram_ready=0.
- rst mid-burst: state goes to IDLE and the beat counter clears. Memory keeps all beats already written.

## Timing
- Request presented in cycle c and accepted.
- Read beats: valid in cycles c+LATENCY .. c+LATENCY+beats-1.
- Write beats: consumed in cycles c+LATENCY-1 .. c+LATENCY+beats-2.
- Write-done pulse: cycle c+LATENCY+beats-1.
- ram_ready is low from c+1 through the final valid cycle and high again the cycle after.
- ram_wr_accept is combinational from the state, plus ram_wr && !ram_rd in IDLE when LATENCY==1.
- Reset values: ram_data_rd=0, ram_data_valid=0, ram_wr_accept=0, ram_ready=1.

## Structure
- Package ram_model_pkg holds:
  - the state enum;
  - a function for the init byte pattern;
  - a function for burst-length legalisation (non-power-of-two or out-of-range -> 1).
- One sub-module, burst_addr_gen, is natural: it computes the wrapped beat address from the start word, beats and beat index.

## Test plan
- LATENCY=1, read len 1 at 0x0020 -> ram_data_valid the next cycle, data 0x08080808.
- LATENCY=3, read len 4 at 0x0028 -> beats 0x0A0A0A0A, 0x0B0B0B0B, 0x08080808, 0x09090909 in c+3..c+6; ram_ready low c+1..c+6.
- Write len 1, be=0001, data 0x12345678 at 0xD030 -> done pulse at c+1. Read back gives 0x0C0C0C78.
- ram_rd and ram_wr together at 0x0040 -> read beat 0x10101010 returned; memory unchanged; ram_wr_accept never high.
- ram_burst_len=3 read at 0x0004 -> exactly one beat, 0x01010101.
- LATENCY=2, write len 4 at 0x0100 with rst asserted after beat 1 -> beats 0–1 written, words 0x42–0x43 unchanged; outputs at reset values; a new request is accepted next cycle.
